pong_draw_datapath: RTL and testbench

- Datapath stage directly downstream of the paddle/ball draw-control FSM in Motion Pong. It consumes the FSM's load, plot, counter-enable and colour-select strobes.
- It produces per-pixel VGA-adapter coordinates, colour and write-enable for a W×H sprite. It returns done (sprite pass finished) and waited (frame delay elapsed) to the FSM.

---
 rtl/pong_draw_pkg.sv | 26 ++
 rtl/pong_draw_datapath_frame_delay_counter.sv | 33 +++
 rtl/pong_draw_datapath.sv | 116 +++++++++++
 tb/tb_pong_draw_datapath.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pong_draw_pkg.sv
// Shared constants for the Motion Pong draw path.
// Screen geometry, sprite sizes, frame timing and colours.
package pong_draw_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int SCR_X_W  = 8;
  localparam int SCR_Y_W  = 7;
  localparam int SCR_COL_W = 3;

  localparam int PADDLE_W = 4;
  localparam int PADDLE_H = 4;
  localparam int BALL_W   = 4;
  localparam int BALL_H   = 4;

  // 60 Hz frame tick at a 50 MHz clock.
  localparam int DEF_WAIT_CYCLES = 833333;

  localparam logic [SCR_COL_W-1:0] COLOUR_BLACK = 3'b000;
  localparam logic [SCR_COL_W-1:0] COLOUR_WHITE = 3'b111;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pong_draw_datapath_frame_delay_counter.sv
// Frame-delay counter: pulses waited once every WAIT_CYCLES
// enabled cycles; dropping enable restarts the count.
import pong_draw_pkg::*;

module frame_delay_counter #(
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic clock,
  input  logic resetn,
  input  logic enable,
  output logic waited
);

  localparam int CW = cnt_w(WAIT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == LAST);

  always_ff @(posedge clock) begin
    if (!resetn)
      r_cnt <= '0;
    else if (!enable || w_last)
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + 1'b1;
  end

  assign waited = enable & w_last;

endmodule

// File: rtl/pong_draw_datapath.sv
// Sprite draw datapath: walks a W x H sprite from a loaded
// base, emitting VGA pixels, and times the frame delay.
import pong_draw_pkg::*;

module pong_draw_datapath #(
  parameter int SPR_W       = BALL_W,
  parameter int SPR_H       = BALL_H,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int X_W         = SCR_X_W,
  parameter int Y_W         = SCR_Y_W,
  parameter int COL_W       = SCR_COL_W,
  parameter logic [COL_W-1:0] BG_COLOUR = '0
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             ld_x,
  input  logic             ld_y,
  input  logic [X_W-1:0]   x_in,
  input  logic [Y_W-1:0]   y_in,
  input  logic [COL_W-1:0] colour_in,
  input  logic             plot_in,
  input  logic             enable_pos,
  input  logic             enable_wait,
  input  logic             sel_col,
  output logic [X_W-1:0]   x_out,
  output logic [Y_W-1:0]   y_out,
  output logic [COL_W-1:0] colour_out,
  output logic             plot_out,
  output logic             done,
  output logic             waited
);

  localparam int OXW = cnt_w(SPR_W);
  localparam int OYW = cnt_w(SPR_H);
  localparam logic [OXW-1:0] LAST_X = OXW'(SPR_W - 1);
  localparam logic [OYW-1:0] LAST_Y = OYW'(SPR_H - 1);

  logic [X_W-1:0]   r_x_base;
  logic [Y_W-1:0]   r_y_base;
  logic [COL_W-1:0] r_col;
  logic [OXW-1:0]   r_off_x;
  logic [OYW-1:0]   r_off_y;

  logic [OXW-1:0]   w_nx;
  logic [OYW-1:0]   w_ny;
  logic             w_last_x;
  logic             w_last_y;

  assign w_last_x = (r_off_x == LAST_X);
  assign w_last_y = (r_off_y == LAST_Y);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_x_base <= '0;
      r_y_base <= '0;
      r_col    <= '0;
    end else begin
      if (ld_x) begin
        r_x_base <= x_in;
        r_col    <= colour_in;
      end
      if (ld_y)
        r_y_base <= y_in;
    end
  end

  // Raster order: x fastest, then y; last pixel wraps to (0,0).
  always_comb begin
    w_nx = '0;
    w_ny = '0;
    unique case (1'b1)
      !enable_pos: begin
        w_nx = '0;
        w_ny = '0;
      end
      enable_pos && !w_last_x: begin
        w_nx = r_off_x + 1'b1;
        w_ny = r_off_y;
      end
      enable_pos && w_last_x && !w_last_y: begin
        w_nx = '0;
        w_ny = r_off_y + 1'b1;
      end
      default: begin
        w_nx = '0;
        w_ny = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_off_x <= '0;
      r_off_y <= '0;
    end else begin
      r_off_x <= w_nx;
      r_off_y <= w_ny;
    end
  end

  assign x_out      = r_x_base + X_W'(r_off_x);
  assign y_out      = r_y_base + Y_W'(r_off_y);
  assign colour_out = sel_col ? BG_COLOUR : r_col;
  assign plot_out   = plot_in;
  assign done       = enable_pos & w_last_x & w_last_y;

  frame_delay_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait (
    .clock (clock),
    .resetn(resetn),
    .enable(enable_wait),
    .waited(waited)
  );

endmodule

// File: tb/tb_pong_draw_datapath.sv
// Randomised + directed bench for pong_draw_datapath against a
// pixel-index reference model; second instance covers 1x1 sprites.
module tb_pong_draw_datapath;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int WT = 5;

  logic       clock = 0;
  logic       resetn, ld_x, ld_y, plot_in;
  logic       enable_pos, enable_wait, sel_col;
  logic [7:0] x_in;
  logic [6:0] y_in;
  logic [2:0] colour_in;

  logic [7:0] x_out, x1;
  logic [6:0] y_out, y1;
  logic [2:0] colour_out, c1;
  logic       plot_out, done, waited;
  logic       p1, done1, waited1;

  int n_vec = 0;
  int n_err = 0;

  int xb, yb, col, pix, wc;
  int cyc_done, cyc_wait, n_done, n_wait;

  always #5 clock = ~clock;

  pong_draw_datapath #(
    .SPR_W(W), .SPR_H(H), .WAIT_CYCLES(WT)
  ) dut (
    .clock(clock), .resetn(resetn),
    .ld_x(ld_x), .ld_y(ld_y),
    .x_in(x_in), .y_in(y_in), .colour_in(colour_in),
    .plot_in(plot_in), .enable_pos(enable_pos),
    .enable_wait(enable_wait), .sel_col(sel_col),
    .x_out(x_out), .y_out(y_out), .colour_out(colour_out),
    .plot_out(plot_out), .done(done), .waited(waited)
  );

  pong_draw_datapath #(
    .SPR_W(1), .SPR_H(1), .WAIT_CYCLES(1)
  ) dut1 (
    .clock(clock), .resetn(resetn),
    .ld_x(ld_x), .ld_y(ld_y),
    .x_in(x_in), .y_in(y_in), .colour_in(colour_in),
    .plot_in(plot_in), .enable_pos(enable_pos),
    .enable_wait(enable_wait), .sel_col(sel_col),
    .x_out(x1), .y_out(y1), .colour_out(c1),
    .plot_out(p1), .done(done1), .waited(waited1)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int ex, ey, ec;
    ex = (xb + pix % W) % 256;
    ey = (yb + pix / W) % 128;
    ec = sel_col ? 0 : col;
    chk("x_out", int'(x_out), ex);
    chk("y_out", int'(y_out), ey);
    chk("colour", int'(colour_out), ec);
    chk("plot", int'(plot_out), int'(plot_in));
    chk("done", int'(done), int'(enable_pos && pix == W*H-1));
    chk("waited", int'(waited), int'(enable_wait && wc == WT-1));
    chk("x1", int'(x1), xb);
    chk("y1", int'(y1), yb);
    chk("colour1", int'(c1), ec);
    chk("done1", int'(done1), int'(enable_pos));
    chk("waited1", int'(waited1), int'(enable_wait));
  endtask

  task automatic model_edge();
    if (!resetn) begin
      xb = 0; yb = 0; col = 0; pix = 0; wc = 0;
    end else begin
      if (ld_x) begin
        xb = int'(x_in);
        col = int'(colour_in);
      end
      if (ld_y) yb = int'(y_in);
      pix = enable_pos ? (pix + 1) % (W*H) : 0;
      wc  = enable_wait ? (wc + 1) % WT : 0;
    end
  endtask

  // One clock: check outputs mid-cycle, then advance the model.
  task automatic cycle(input int idx);
    @(negedge clock);
    check_outputs();
    if (done) begin
      n_done++;
      cyc_done = idx;
    end
    if (waited) begin
      n_wait++;
      cyc_wait = idx;
    end
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic idle();
    ld_x = 0; ld_y = 0; plot_in = 0;
    enable_pos = 0; enable_wait = 0; sel_col = 0;
  endtask

  task automatic load(input int x, input int y, input int c);
    idle();
    ld_x = 1; ld_y = 1;
    x_in = 8'(x); y_in = 7'(y); colour_in = 3'(c);
    cycle(0);
    ld_x = 0; ld_y = 0;
  endtask

  task automatic pass(input int sc, input int xw, input int yw);
    int n;
    load(xw, yw, 3);
    sel_col = 1'(sc);
    enable_pos = 1; plot_in = 1;
    n_done = 0; cyc_done = 0;
    for (int i = 1; i <= 16; i++) cycle(i);
    chk("pass_done_cnt", n_done, 1);
    chk("pass_done_at", cyc_done, 16);
    n = 0;
    enable_pos = 0;
  endtask

  initial begin
    idle();
    x_in = 0; y_in = 0; colour_in = 0;
    resetn = 0;
    xb = 0; yb = 0; col = 0; pix = 0; wc = 0;
    @(posedge clock);
    #1;
    cycle(0);
    chk("rst_x", int'(x_out), 0);
    chk("rst_y", int'(y_out), 0);
    resetn = 1;

    pass(0, 10, 20);
    pass(1, 10, 20);
    pass(0, 158, 118);
    pass(0, 254, 126);

    idle();
    enable_wait = 1; n_wait = 0;
    for (int i = 1; i <= 12; i++) cycle(i);
    chk("wait_cnt12", n_wait, 2);
    enable_wait = 0;
    cycle(0);
    enable_wait = 1;
    cycle(1);
    cycle(2);
    enable_wait = 0;
    cycle(3);
    enable_wait = 1; n_wait = 0; cyc_wait = 0;
    for (int i = 1; i <= 6; i++) cycle(i);
    chk("wait_restart_at", cyc_wait, 5);
    chk("wait_restart_cnt", n_wait, 1);

    load(40, 50, 5);
    enable_pos = 1; plot_in = 1;
    for (int i = 1; i <= 5; i++) cycle(i);
    resetn = 0;
    cycle(6);
    resetn = 1;
    idle();
    cycle(0);
    chk("abort_x", int'(x_out), 0);
    chk("abort_y", int'(y_out), 0);
    load(60, 70, 6);
    enable_pos = 1; n_done = 0; cyc_done = 0;
    for (int i = 1; i <= 16; i++) cycle(i);
    chk("abort_done_at", cyc_done, 16);
    chk("abort_done_cnt", n_done, 1);

    idle();
    cycle(0);
    enable_pos = 1; enable_wait = 1;
    n_done = 0; n_wait = 0;
    for (int i = 1; i <= 16; i++) cycle(i);
    chk("sim_done_cnt", n_done, 1);
    chk("sim_wait_cnt", n_wait, 3);

    for (int i = 0; i < 600; i++) begin
      resetn      = ($urandom_range(0, 59) != 0);
      ld_x        = ($urandom_range(0, 7) == 0);
      ld_y        = ($urandom_range(0, 7) == 0);
      x_in        = 8'($urandom);
      y_in        = 7'($urandom);
      colour_in   = 3'($urandom);
      plot_in     = 1'($urandom);
      sel_col     = 1'($urandom);
      enable_pos  = ($urandom_range(0, 11) != 0);
      enable_wait = ($urandom_range(0, 9) != 0);
      cycle(i);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
